// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-high, bit 6 = A ... bit 0 = G) and the
// receive-side decoder FSM state type, used by both encoder and decoder paths.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h7E;
  localparam logic [6:0] SEG7_1     = 7'h30;
  localparam logic [6:0] SEG7_2     = 7'h6D;
  localparam logic [6:0] SEG7_3     = 7'h79;
  localparam logic [6:0] SEG7_4     = 7'h33;
  localparam logic [6:0] SEG7_5     = 7'h5B;
  localparam logic [6:0] SEG7_6     = 7'h5F;
  localparam logic [6:0] SEG7_7     = 7'h70;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h7B;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_B     = 7'h1F;
  localparam logic [6:0] SEG7_C     = 7'h4E;
  localparam logic [6:0] SEG7_D     = 7'h3D;
  localparam logic [6:0] SEG7_E     = 7'h4F;
  localparam logic [6:0] SEG7_F     = 7'h47;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_TRACK  = 2'd0,
    S_COMMIT = 2'd1,
    S_HOLD   = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-high segment pattern to {legal, blank, value}.
// Hex letters A-F are legal only when SEG7_DECODE_HEX_EN is defined.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_Pattern,
  output logic       o_Legal,
  output logic       o_Blank,
  output logic [3:0] o_Value
);

  always_comb begin
    o_Legal = 1'b1;
    o_Value = '0;
    o_Blank = (i_Pattern == SEG7_BLANK);
    case (i_Pattern)
      SEG7_0:  o_Value = 4'd0;
      SEG7_1:  o_Value = 4'd1;
      SEG7_2:  o_Value = 4'd2;
      SEG7_3:  o_Value = 4'd3;
      SEG7_4:  o_Value = 4'd4;
      SEG7_5:  o_Value = 4'd5;
      SEG7_6:  o_Value = 4'd6;
      SEG7_7:  o_Value = 4'd7;
      SEG7_8:  o_Value = 4'd8;
      SEG7_9:  o_Value = 4'd9;
`ifdef SEG7_DECODE_HEX_EN
      SEG7_A:  o_Value = 4'd10;
      SEG7_B:  o_Value = 4'd11;
      SEG7_C:  o_Value = 4'd12;
      SEG7_D:  o_Value = 4'd13;
      SEG7_E:  o_Value = 4'd14;
      SEG7_F:  o_Value = 4'd15;
`endif
      default: o_Legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_binary.sv
// Samples active-low 7-segment lines, requires STABLE_CYCLES of stability, then
// decodes the accepted pattern to a digit with valid/strobe/blank/error flags.
module seg7_to_binary
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segment,
  output logic [3:0] o_Digit,
  output logic       o_Valid,
  output logic       o_Digit_Stb,
  output logic       o_Blank,
  output logic       o_Error
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       r_Sync1;
  logic [6:0]       r_Sync2;
  logic [6:0]       r_Cand;
  logic [6:0]       r_Acc;
  logic [CNT_W-1:0] r_Cnt;
  seg7_state_e      r_State;
  logic [3:0]       r_Digit;
  logic             r_Valid;
  logic             r_Digit_Stb;
  logic             r_Blank;
  logic             r_Error;

  logic             w_Legal;
  logic             w_Blank;
  logic [3:0]       w_Value;

  seg7_pattern_decode u_decode (
    .i_Pattern (r_Cand),
    .o_Legal   (w_Legal),
    .o_Blank   (w_Blank),
    .o_Value   (w_Value)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1 <= SEG7_BLANK;
      r_Sync2 <= SEG7_BLANK;
    end else begin
      r_Sync1 <= ~i_Segment;
      r_Sync2 <= r_Sync1;
    end
  end

  // A change on the synchronized pattern takes priority over a terminal count.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= S_TRACK;
      r_Cand      <= SEG7_BLANK;
      r_Acc       <= SEG7_BLANK;
      r_Cnt       <= '0;
      r_Digit     <= '0;
      r_Valid     <= 1'b0;
      r_Digit_Stb <= 1'b0;
      r_Blank     <= 1'b1;
      r_Error     <= 1'b0;
    end else begin
      r_Digit_Stb <= 1'b0;
      case (r_State)
        S_TRACK: begin
          if (r_Sync2 != r_Cand) begin
            r_Cand <= r_Sync2;
            r_Cnt  <= '0;
          end else if (r_Cnt == CNT_LAST) begin
            r_State <= S_COMMIT;
          end else begin
            r_Cnt <= r_Cnt + CNT_W'(1);
          end
        end
        S_COMMIT: begin
          if (r_Cand != r_Acc) begin
            r_Acc   <= r_Cand;
            r_Valid <= w_Legal;
            r_Blank <= w_Blank;
            r_Error <= !w_Legal && !w_Blank;
            if (w_Legal) begin
              r_Digit     <= w_Value;
              r_Digit_Stb <= 1'b1;
            end
          end
          r_State <= S_HOLD;
        end
        S_HOLD: begin
          if (r_Sync2 != r_Cand) begin
            r_Cand  <= r_Sync2;
            r_Cnt   <= '0;
            r_State <= S_TRACK;
          end
        end
        default: r_State <= S_TRACK;
      endcase
    end
  end

  assign o_Digit     = r_Digit;
  assign o_Valid     = r_Valid;
  assign o_Digit_Stb = r_Digit_Stb;
  assign o_Blank     = r_Blank;
  assign o_Error     = r_Error;

endmodule

// File: tb/tb_seg7_to_binary.sv
// Self-checking bench for seg7_to_binary with STABLE_CYCLES=4; honours SEG7_DECODE_HEX_EN.
module tb_seg7_to_binary;

  localparam int unsigned STABLE = 4;

  localparam logic [6:0] PAT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
`ifdef SEG7_DECODE_HEX_EN
  localparam int unsigned NUM_LEGAL = 16;
`else
  localparam int unsigned NUM_LEGAL = 10;
`endif

  logic       i_Clk;
  logic       i_Rst_L;
  logic [6:0] i_Segment;
  logic [3:0] o_Digit;
  logic       o_Valid;
  logic       o_Digit_Stb;
  logic       o_Blank;
  logic       o_Error;

  int checks   = 0;
  int failures = 0;
  int stb_cnt  = 0;

  // Reference model of the accepted state (active-high pattern and flags).
  logic [6:0] m_acc;
  logic [3:0] m_digit;
  logic       m_valid, m_blank, m_err;

  seg7_to_binary #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Segment   (i_Segment),
    .o_Digit     (o_Digit),
    .o_Valid     (o_Valid),
    .o_Digit_Stb (o_Digit_Stb),
    .o_Blank     (o_Blank),
    .o_Error     (o_Error)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (o_Digit_Stb === 1'b1) stb_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic legal, output logic [3:0] val);
    legal = 1'b0;
    val   = 4'd0;
    for (int i = 0; i < int'(NUM_LEGAL); i++)
      if (PAT[i] == p) begin
        legal = 1'b1;
        val   = 4'(i);
      end
  endfunction

  // Apply an accepted pattern to the model; returns the number of strobes expected.
  function automatic int ref_accept(input logic [6:0] p);
    logic       legal;
    logic [3:0] val;
    ref_decode(p, legal, val);
    if (p == m_acc) return 0;
    m_acc   = p;
    m_valid = legal;
    m_blank = (p == 7'h00);
    m_err   = !legal && (p != 7'h00);
    if (legal) m_digit = val;
    return legal ? 1 : 0;
  endfunction

  task automatic test_reset();
    int s0;
    i_Rst_L   = 1'b0;
    i_Segment = 7'h7F;
    step(3);
    checks++; if (o_Digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", o_Digit); end
    checks++; if (o_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_Valid); end
    checks++; if (o_Digit_Stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", o_Digit_Stb); end
    checks++; if (o_Blank !== 1'b1) begin failures++; $display("FAIL reset_blank got=%b exp=1", o_Blank); end
    checks++; if (o_Error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", o_Error); end
    s0 = stb_cnt;
    i_Rst_L = 1'b1;
    step(20);
    checks++; if (stb_cnt - s0 != 0) begin failures++; $display("FAIL reset_release_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (o_Blank !== 1'b1 || o_Valid !== 1'b0) begin failures++; $display("FAIL reset_release_flags blank=%b valid=%b exp blank=1 valid=0", o_Blank, o_Valid); end
  endtask

  task automatic test_digit5();
    int hits = 0;
    int first = -1;
    i_Segment = ~7'h5B;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_Clk); #1;
      if (o_Digit_Stb === 1'b1) begin
        hits++;
        if (first < 0) first = i;
      end
    end
    checks++; if (hits != 1 || first != int'(STABLE) + 3) begin failures++; $display("FAIL digit5_stb_timing hits=%0d edge=%0d exp hits=1 edge=%0d", hits, first, STABLE + 3); end
    checks++; if (o_Digit !== 4'd5) begin failures++; $display("FAIL digit5_value got=%0d exp=5", o_Digit); end
    checks++; if (o_Valid !== 1'b1 || o_Blank !== 1'b0 || o_Error !== 1'b0) begin failures++; $display("FAIL digit5_flags v=%b b=%b e=%b exp 1/0/0", o_Valid, o_Blank, o_Error); end
  endtask

  task automatic test_glitch();
    int s0 = stb_cnt;
    i_Segment = ~7'h30;
    step(3);
    i_Segment = ~7'h5B;
    step(15);
    checks++; if (stb_cnt - s0 != 0) begin failures++; $display("FAIL glitch_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (o_Digit !== 4'd5 || o_Valid !== 1'b1) begin failures++; $display("FAIL glitch_hold digit=%0d valid=%b exp 5/1", o_Digit, o_Valid); end
  endtask

  task automatic test_illegal();
    int s0 = stb_cnt;
    i_Segment = ~7'h01;
    step(15);
    checks++; if (stb_cnt - s0 != 0) begin failures++; $display("FAIL illegal_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (o_Error !== 1'b1 || o_Valid !== 1'b0 || o_Blank !== 1'b0) begin failures++; $display("FAIL illegal_flags e=%b v=%b b=%b exp 1/0/0", o_Error, o_Valid, o_Blank); end
    checks++; if (o_Digit !== 4'd5) begin failures++; $display("FAIL illegal_digit got=%0d exp=5", o_Digit); end
  endtask

  task automatic test_hex();
    int s0 = stb_cnt;
    i_Segment = ~7'h77;
    step(15);
`ifdef SEG7_DECODE_HEX_EN
    checks++; if (stb_cnt - s0 != 1) begin failures++; $display("FAIL hex_stb got=%0d exp=1", stb_cnt - s0); end
    checks++; if (o_Digit !== 4'd10 || o_Valid !== 1'b1 || o_Error !== 1'b0) begin failures++; $display("FAIL hex_value digit=%0d v=%b e=%b exp 10/1/0", o_Digit, o_Valid, o_Error); end
`else
    checks++; if (stb_cnt - s0 != 0) begin failures++; $display("FAIL hex_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (o_Error !== 1'b1 || o_Valid !== 1'b0 || o_Digit !== 4'd5) begin failures++; $display("FAIL hex_illegal e=%b v=%b digit=%0d exp 1/0/5", o_Error, o_Valid, o_Digit); end
`endif
  endtask

  // Input held STABLE cycles loses to the following change; STABLE+1 cycles is accepted.
  task automatic test_boundary();
    int s0 = stb_cnt;
    i_Segment = ~7'h30;
    step(STABLE);
    i_Segment = ~7'h6D;
    step(12);
    checks++; if (stb_cnt - s0 != 1) begin failures++; $display("FAIL boundary_short_stb got=%0d exp=1", stb_cnt - s0); end
    checks++; if (o_Digit !== 4'd2) begin failures++; $display("FAIL boundary_short_digit got=%0d exp=2", o_Digit); end
    s0 = stb_cnt;
    i_Segment = ~7'h30;
    step(STABLE + 1);
    i_Segment = ~7'h6D;
    step(12);
    checks++; if (stb_cnt - s0 != 2) begin failures++; $display("FAIL boundary_exact_stb got=%0d exp=2", stb_cnt - s0); end
    checks++; if (o_Digit !== 4'd2 || o_Valid !== 1'b1) begin failures++; $display("FAIL boundary_exact_digit got=%0d valid=%b exp 2/1", o_Digit, o_Valid); end
  endtask

  task automatic test_back_to_back();
    int s0 = stb_cnt;
    for (int d = 0; d < 10; d++) begin
      i_Segment = ~PAT[d];
      step(9);
      checks++; if (o_Digit !== 4'(d) || o_Valid !== 1'b1) begin failures++; $display("FAIL b2b_digit got=%0d valid=%b exp %0d/1", o_Digit, o_Valid, d); end
    end
    checks++; if (stb_cnt - s0 != 10) begin failures++; $display("FAIL b2b_stb_count got=%0d exp=10", stb_cnt - s0); end
  endtask

  task automatic test_random();
    logic [6:0] prev = 7'h7B;
    logic [6:0] p;
    int s0, len, exp_stb;
    m_acc = 7'h7B; m_digit = 4'd9; m_valid = 1'b1; m_blank = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 60; n++) begin
      do begin
        case ($urandom_range(0, 3))
          0: p = PAT[$urandom_range(0, 9)];
          1: p = PAT[$urandom_range(10, 15)];
          2: p = 7'h00;
          default: p = 7'($urandom);
        endcase
      end while (p == prev);
      prev = p;
      s0 = stb_cnt;
      i_Segment = ~p;
      if ($urandom_range(0, 1) == 0) begin
        len = int'($urandom_range(1, 3));
        step(len);
        checks++; if (stb_cnt - s0 != 0) begin failures++; $display("FAIL rand_glitch_stb pat=%h got=%0d exp=0", p, stb_cnt - s0); end
      end else begin
        len = int'($urandom_range(9, 14));
        exp_stb = ref_accept(p);
        step(len);
        checks++; if (stb_cnt - s0 != exp_stb) begin failures++; $display("FAIL rand_stb pat=%h got=%0d exp=%0d", p, stb_cnt - s0, exp_stb); end
        checks++;
        if (o_Digit !== m_digit || o_Valid !== m_valid || o_Blank !== m_blank || o_Error !== m_err) begin
          failures++;
          $display("FAIL rand_flags pat=%h got d=%0d v=%b b=%b e=%b exp d=%0d v=%b b=%b e=%b",
                   p, o_Digit, o_Valid, o_Blank, o_Error, m_digit, m_valid, m_blank, m_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int s0;
    i_Segment = ~7'h30;
    step(2);
    i_Rst_L   = 1'b0;
    i_Segment = 7'h7F;
    #1;
    checks++;
    if (o_Digit !== 4'd0 || o_Valid !== 1'b0 || o_Digit_Stb !== 1'b0 || o_Blank !== 1'b1 || o_Error !== 1'b0) begin
      failures++;
      $display("FAIL midreset_values d=%0d v=%b s=%b b=%b e=%b exp 0/0/0/1/0", o_Digit, o_Valid, o_Digit_Stb, o_Blank, o_Error);
    end
    step(2);
    s0 = stb_cnt;
    i_Rst_L = 1'b1;
    step(20);
    checks++; if (stb_cnt - s0 != 0) begin failures++; $display("FAIL midreset_release_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (o_Blank !== 1'b1 || o_Digit !== 4'd0 || o_Valid !== 1'b0) begin failures++; $display("FAIL midreset_release_flags b=%b d=%0d v=%b exp 1/0/0", o_Blank, o_Digit, o_Valid); end
  endtask

  initial begin
    i_Rst_L   = 1'b0;
    i_Segment = 7'h7F;
    test_reset();
    test_digit5();
    test_glitch();
    test_illegal();
    test_hex();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
